alu_rs_age_ordered: RTL and testbench

//  Parametrised ALU reservation station; next generation of the ALU RS. Sits between dispatch and the ALU.

---
 rtl/alu_rs_age_ordered.sv | 203 ++++++++++++++++++++
 tb/tb_alu_rs_age_ordered.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_age_ordered.sv
// ALU reservation station: DEPTH entries, CDB wakeup (incl. dispatch bypass), oldest-ready issue via age matrix.
// Latency: dispatch-ready op reaches iss_valid 2 cycles after dispatch; CDB wake to iss_valid is 2 cycles minimum.
// Backpressure: iss_ready=0 with iss_valid=1 freezes the output register; rs_full drops dispatches.
module alu_rs_age_ordered #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4,
    parameter int OP_W   = 6,
    parameter int NCDB   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic                    clear,
    input  logic                    disp_valid,
    input  logic [OP_W-1:0]         disp_op,
    input  logic [DATA_W-1:0]       disp_imm,
    input  logic [DATA_W-1:0]       disp_pc,
    input  logic                    disp_rs1_valid,
    input  logic [DATA_W-1:0]       disp_rs1_data,
    input  logic [TAG_W-1:0]        disp_rs1_tag,
    input  logic                    disp_rs2_valid,
    input  logic [DATA_W-1:0]       disp_rs2_data,
    input  logic [TAG_W-1:0]        disp_rs2_tag,
    input  logic [TAG_W-1:0]        disp_dest_tag,
    output logic                    rs_full,
    output logic [$clog2(DEPTH):0]  rs_count,
    input  logic [NCDB-1:0]         cdb_valid,
    input  logic [NCDB*TAG_W-1:0]   cdb_tag,
    input  logic [NCDB*DATA_W-1:0]  cdb_data,
    output logic                    iss_valid,
    input  logic                    iss_ready,
    output logic [OP_W-1:0]         iss_op,
    output logic [DATA_W-1:0]       iss_imm,
    output logic [DATA_W-1:0]       iss_pc,
    output logic [DATA_W-1:0]       iss_rs1,
    output logic [DATA_W-1:0]       iss_rs2,
    output logic [TAG_W-1:0]        iss_dest_tag
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic              rs1_v;
        logic [DATA_W-1:0] rs1_d;
        logic [TAG_W-1:0]  rs1_t;
        logic              rs2_v;
        logic [DATA_W-1:0] rs2_d;
        logic [TAG_W-1:0]  rs2_t;
        logic [TAG_W-1:0]  dest;
    } ent_t;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
        logic [DATA_W-1:0] rs1;
        logic [DATA_W-1:0] rs2;
        logic [TAG_W-1:0]  dest;
    } iss_t;

    ent_t             ent_q   [DEPTH];
    ent_t             ent_d   [DEPTH];
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [DEPTH-1:0] vld_q, vld_d;
    logic [CW-1:0]    count_q, count_d;
    iss_t             iss_q, iss_d;
    logic             iss_vld_q, iss_vld_d;

    logic [DEPTH-1:0] ready, win;
    logic             sel, acc, found;
    logic [IW-1:0]    ins_idx;
    logic [DATA_W:0]  lk1, lk2;

    // Returns {hit, data}; scanning high-to-low lets the lowest matching channel win.
    function automatic logic [DATA_W:0] cdb_lookup(input logic [TAG_W-1:0] tag);
        logic [DATA_W:0] r;
        r = '0;
        for (int c = NCDB - 1; c >= 0; c--) begin
            if (cdb_valid[c] && cdb_tag[c*TAG_W +: TAG_W] == tag)
                r = {1'b1, cdb_data[c*DATA_W +: DATA_W]};
        end
        return r;
    endfunction

    always_comb begin
        ent_d     = ent_q;
        older_d   = older_q;
        vld_d     = vld_q;
        iss_d     = iss_q;
        iss_vld_d = iss_vld_q;
        ins_idx   = '0;
        found     = 1'b0;
        lk1       = '0;
        lk2       = '0;

        for (int k = 0; k < DEPTH; k++)
            ready[k] = vld_q[k] & ent_q[k].rs1_v & ent_q[k].rs2_v;
        // older_q[k][j] set means j is older than k; k wins if no older entry is ready.
        for (int k = 0; k < DEPTH; k++)
            win[k] = ready[k] & ~|(ready & older_q[k]);

        sel = (!iss_vld_q || iss_ready) && (|win);
        acc = disp_valid && (count_q != CW'(DEPTH));

        for (int k = 0; k < DEPTH; k++) begin
            if (!ent_q[k].rs1_v) begin
                lk1 = cdb_lookup(ent_q[k].rs1_t);
                if (lk1[DATA_W]) begin
                    ent_d[k].rs1_v = 1'b1;
                    ent_d[k].rs1_d = lk1[DATA_W-1:0];
                end
            end
            if (!ent_q[k].rs2_v) begin
                lk2 = cdb_lookup(ent_q[k].rs2_t);
                if (lk2[DATA_W]) begin
                    ent_d[k].rs2_v = 1'b1;
                    ent_d[k].rs2_d = lk2[DATA_W-1:0];
                end
            end
        end

        if (sel) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (win[k]) begin
                    iss_d.op   = ent_q[k].op;
                    iss_d.imm  = ent_q[k].imm;
                    iss_d.pc   = ent_q[k].pc;
                    iss_d.rs1  = ent_q[k].rs1_d;
                    iss_d.rs2  = ent_q[k].rs2_d;
                    iss_d.dest = ent_q[k].dest;
                    vld_d[k]   = 1'b0;
                end
            end
            iss_vld_d = 1'b1;
        end else if (iss_ready) begin
            iss_vld_d = 1'b0;
        end

        // Insert slot comes from the pre-select free set, so it never collides with the winner.
        for (int k = 0; k < DEPTH; k++) begin
            if (!vld_q[k] && !found) begin
                ins_idx = IW'(k);
                found   = 1'b1;
            end
        end

        if (acc) begin
            ent_d[ins_idx].op    = disp_op;
            ent_d[ins_idx].imm   = disp_imm;
            ent_d[ins_idx].pc    = disp_pc;
            ent_d[ins_idx].dest  = disp_dest_tag;
            ent_d[ins_idx].rs1_t = disp_rs1_tag;
            ent_d[ins_idx].rs2_t = disp_rs2_tag;
            lk1 = cdb_lookup(disp_rs1_tag);
            lk2 = cdb_lookup(disp_rs2_tag);
            ent_d[ins_idx].rs1_v = disp_rs1_valid | lk1[DATA_W];
            ent_d[ins_idx].rs1_d = disp_rs1_valid ? disp_rs1_data : lk1[DATA_W-1:0];
            ent_d[ins_idx].rs2_v = disp_rs2_valid | lk2[DATA_W];
            ent_d[ins_idx].rs2_d = disp_rs2_valid ? disp_rs2_data : lk2[DATA_W-1:0];
            vld_d[ins_idx]   = 1'b1;
            older_d[ins_idx] = vld_q;
            for (int i = 0; i < DEPTH; i++)
                older_d[i][ins_idx] = 1'b0;
        end

        count_d = count_q + CW'(acc) - CW'(sel);
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k]   <= '0;
                older_q[k] <= '0;
            end
            vld_q     <= '0;
            count_q   <= '0;
            iss_q     <= '0;
            iss_vld_q <= 1'b0;
        end else if (rdy) begin
            ent_q     <= ent_d;
            older_q   <= older_d;
            vld_q     <= vld_d;
            count_q   <= count_d;
            iss_q     <= iss_d;
            iss_vld_q <= iss_vld_d;
        end
    end

    assign rs_full      = (count_q == CW'(DEPTH));
    assign rs_count     = count_q;
    assign iss_valid    = iss_vld_q;
    assign iss_op       = iss_q.op;
    assign iss_imm      = iss_q.imm;
    assign iss_pc       = iss_q.pc;
    assign iss_rs1      = iss_q.rs1;
    assign iss_rs2      = iss_q.rs2;
    assign iss_dest_tag = iss_q.dest;
endmodule

// File: tb/tb_alu_rs_age_ordered.sv
// Bench for alu_rs_age_ordered: directed scenarios plus random traffic against an in-order queue model.
module tb_alu_rs_age_ordered;
    logic        clk = 0;
    logic        rst = 1, rdy = 1, clear = 0;
    logic        disp_valid = 0;
    logic [5:0]  disp_op = 0;
    logic [31:0] disp_imm = 0, disp_pc = 0;
    logic        disp_rs1_valid = 0, disp_rs2_valid = 0;
    logic [31:0] disp_rs1_data = 0, disp_rs2_data = 0;
    logic [3:0]  disp_rs1_tag = 0, disp_rs2_tag = 0, disp_dest_tag = 0;
    logic        rs_full;
    logic [4:0]  rs_count;
    logic [3:0]  cdb_valid = 0;
    logic [15:0] cdb_tag = 0;
    logic [127:0] cdb_data = 0;
    logic        iss_valid, iss_ready = 1;
    logic [5:0]  iss_op;
    logic [31:0] iss_imm, iss_pc, iss_rs1, iss_rs2;
    logic [3:0]  iss_dest_tag;

    int total = 0, bad = 0;

    alu_rs_age_ordered dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_imm(disp_imm), .disp_pc(disp_pc),
        .disp_rs1_valid(disp_rs1_valid), .disp_rs1_data(disp_rs1_data), .disp_rs1_tag(disp_rs1_tag),
        .disp_rs2_valid(disp_rs2_valid), .disp_rs2_data(disp_rs2_data), .disp_rs2_tag(disp_rs2_tag),
        .disp_dest_tag(disp_dest_tag), .rs_full(rs_full), .rs_count(rs_count),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_op(iss_op), .iss_imm(iss_imm),
        .iss_pc(iss_pc), .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_dest_tag(iss_dest_tag)
    );

    always #5 clk = ~clk;

    // Model: queue order is age order; front-most ready entry is the oldest ready one.
    typedef struct {
        logic [5:0]  op;
        logic [31:0] imm, pc;
        bit          r1v, r2v;
        logic [31:0] r1d, r2d;
        logic [3:0]  r1t, r2t, dest;
    } ment_t;
    ment_t       mq[$];
    bit          m_iv;
    logic [5:0]  m_op;
    logic [31:0] m_imm, m_pc, m_rs1, m_rs2;
    logic [3:0]  m_dest;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cdb_hit(input logic [3:0] tag, output bit hit, output logic [31:0] d);
        hit = 0; d = 0;
        for (int c = 0; c < 4; c++) begin
            if (cdb_valid[c] && cdb_tag[c*4 +: 4] == tag) begin
                hit = 1; d = cdb_data[c*32 +: 32];
                break;
            end
        end
    endtask

    task automatic model_step();
        bit full, hit;
        int pick;
        logic [31:0] d;
        ment_t e;
        if (rst || clear) begin
            mq.delete(); m_iv = 0;
            m_op = 0; m_imm = 0; m_pc = 0; m_rs1 = 0; m_rs2 = 0; m_dest = 0;
        end else if (rdy) begin
            full = (mq.size() == 16);
            pick = -1;
            if (!m_iv || iss_ready)
                for (int i = 0; i < mq.size(); i++)
                    if (mq[i].r1v && mq[i].r2v) begin pick = i; break; end
            if (pick >= 0) begin
                m_iv = 1; m_op = mq[pick].op; m_imm = mq[pick].imm; m_pc = mq[pick].pc;
                m_rs1 = mq[pick].r1d; m_rs2 = mq[pick].r2d; m_dest = mq[pick].dest;
            end else if (iss_ready) m_iv = 0;
            for (int i = 0; i < mq.size(); i++) begin
                if (!mq[i].r1v) begin cdb_hit(mq[i].r1t, hit, d); if (hit) begin mq[i].r1v = 1; mq[i].r1d = d; end end
                if (!mq[i].r2v) begin cdb_hit(mq[i].r2t, hit, d); if (hit) begin mq[i].r2v = 1; mq[i].r2d = d; end end
            end
            if (pick >= 0) mq.delete(pick);
            if (disp_valid && !full) begin
                e.op = disp_op; e.imm = disp_imm; e.pc = disp_pc; e.dest = disp_dest_tag;
                e.r1t = disp_rs1_tag; e.r2t = disp_rs2_tag;
                e.r1v = disp_rs1_valid; e.r1d = disp_rs1_data;
                e.r2v = disp_rs2_valid; e.r2d = disp_rs2_data;
                if (!e.r1v) begin cdb_hit(e.r1t, hit, d); e.r1v = hit; e.r1d = d; end
                if (!e.r2v) begin cdb_hit(e.r2t, hit, d); e.r2v = hit; e.r2d = d; end
                mq.push_back(e);
            end
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        chk("iss_valid", iss_valid, m_iv);
        chk("rs_count", rs_count, mq.size());
        chk("rs_full", rs_full, mq.size() == 16);
        if (m_iv) begin
            chk("iss_op", iss_op, m_op);
            chk("iss_imm", iss_imm, m_imm);
            chk("iss_pc", iss_pc, m_pc);
            chk("iss_rs1", iss_rs1, m_rs1);
            chk("iss_rs2", iss_rs2, m_rs2);
            chk("iss_dest", iss_dest_tag, m_dest);
        end
        rst = 0; clear = 0; rdy = 1; disp_valid = 0; cdb_valid = 0;
    endtask

    task automatic disp(input logic [3:0] dest, input bit v1, input logic [31:0] d1, input logic [3:0] t1,
                        input bit v2, input logic [31:0] d2, input logic [3:0] t2);
        disp_valid = 1; disp_op = 6'(dest + 1); disp_imm = 32'h100 + dest; disp_pc = 32'h4000 + dest;
        disp_dest_tag = dest;
        disp_rs1_valid = v1; disp_rs1_data = d1; disp_rs1_tag = t1;
        disp_rs2_valid = v2; disp_rs2_data = d2; disp_rs2_tag = t2;
    endtask

    task automatic cdb(input int c, input logic [3:0] tag, input logic [31:0] d);
        cdb_valid[c] = 1; cdb_tag[c*4 +: 4] = tag; cdb_data[c*32 +: 32] = d;
    endtask

    initial begin
        // reset state
        rst = 1; step();
        chk("rst_iss_valid", iss_valid, 0); chk("rst_count", rs_count, 0); chk("rst_full", rs_full, 0);
        chk("rst_iss_rs1", iss_rs1, 0); chk("rst_iss_dest", iss_dest_tag, 0); chk("rst_iss_pc", iss_pc, 0);

        // basic ready op: issues two cycles after dispatch presentation
        iss_ready = 1;
        disp(4'd3, 1, 32'd5, 0, 1, 32'd7, 0); step();
        chk("t1_count1", rs_count, 1); chk("t1_notyet", iss_valid, 0);
        step();
        chk("t1_iss", iss_valid, 1); chk("t1_rs1", iss_rs1, 5); chk("t1_rs2", iss_rs2, 7);
        chk("t1_dest", iss_dest_tag, 3); chk("t1_count0", rs_count, 0);

        // ready younger op overtakes waiting older op; wake-to-issue is 2 cycles
        disp(4'd1, 0, 0, 4'd9, 1, 32'h1, 0); step();
        disp(4'd2, 1, 32'h2, 0, 1, 32'h3, 0); step();
        cdb(2, 4'd9, 32'h55); step();
        chk("t2_b_first", iss_dest_tag, 2);
        step();
        chk("t2_a_valid", iss_valid, 1); chk("t2_a_dest", iss_dest_tag, 1); chk("t2_a_rs1", iss_rs1, 32'h55);

        // age beats slot index: older in slot 5, younger in slot 0
        rst = 1; step();
        for (int i = 0; i < 6; i++) begin disp(4'(10 + i), 0, 0, 4'(1 + i), 1, 32'h9, 0); step(); end
        cdb(0, 4'd1, 32'ha1); cdb(1, 4'd2, 32'ha2); cdb(2, 4'd3, 32'ha3); cdb(3, 4'd4, 32'ha4); step();
        cdb(0, 4'd5, 32'ha5); step();
        for (int i = 0; i < 8; i++) step();
        chk("t3_one_left", rs_count, 1);
        disp(4'd7, 1, 32'h77, 0, 1, 32'h78, 0); cdb(1, 4'd6, 32'ha6); step();
        step(); chk("t3_older_first", iss_dest_tag, 15); chk("t3_older_rs1", iss_rs1, 32'ha6);
        step(); chk("t3_younger_next", iss_dest_tag, 7);

        // fill, drop while full (also while a slot is being freed), then recover
        rst = 1; step();
        for (int i = 0; i < 16; i++) begin disp(4'(i), 0, 0, 4'(i), 1, 32'h3, 0); step(); end
        chk("t4_full", rs_full, 1); chk("t4_count16", rs_count, 16);
        disp(4'd5, 1, 1, 0, 1, 2, 0); step();
        chk("t4_drop", rs_count, 16);
        cdb(3, 4'd0, 32'hbeef); step();
        chk("t4_woken_still16", rs_count, 16);
        disp(4'd6, 1, 1, 0, 1, 2, 0); step();
        chk("t4_iss", iss_valid, 1); chk("t4_iss_rs1", iss_rs1, 32'hbeef);
        chk("t4_count15", rs_count, 15); chk("t4_notfull", rs_full, 0);

        // dispatch bypass with two matching channels: ch0 wins
        rst = 1; step();
        disp(4'd9, 1, 32'h1, 0, 0, 0, 4'd4); cdb(0, 4'd4, 32'h11); cdb(3, 4'd4, 32'h22); step();
        step();
        chk("t5_iss", iss_valid, 1); chk("t5_rs2", iss_rs2, 32'h11); chk("t5_dest", iss_dest_tag, 9);

        // stall holds outputs, rdy=0 freezes, clear flushes
        iss_ready = 0;
        disp(4'd11, 1, 32'h5, 0, 1, 32'h6, 0); step();
        disp(4'd12, 1, 32'h7, 0, 1, 32'h8, 0); step();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t6_stall_rs2", iss_rs2, 32'h11); chk("t6_stall_dest", iss_dest_tag, 9);
            chk("t6_stall_count", rs_count, 2);
        end
        iss_ready = 1; rdy = 0; disp(4'd13, 1, 1, 0, 1, 1, 0); step();
        chk("t6_rdy0_count", rs_count, 2); chk("t6_rdy0_dest", iss_dest_tag, 9);
        iss_ready = 0; clear = 1; step();
        chk("t6_clear_valid", iss_valid, 0); chk("t6_clear_count", rs_count, 0);

        // random traffic against the model
        rst = 1; step();
        for (int n = 0; n < 4000; n++) begin
            rdy = ($urandom_range(0, 9) != 0);
            clear = ($urandom_range(0, 299) == 0);
            iss_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) != 0)
                disp(4'($urandom_range(0, 15)), $urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)),
                     $urandom_range(0, 1), $urandom, 4'($urandom_range(0, 15)));
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 3) == 0) cdb(c, 4'($urandom_range(0, 15)), $urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
